ps_tx_scheduler: RTL and testbench

- Transmit scheduler in front of the parallel-to-serial converter.
- Shares the single 8-bit converter input between two byte lanes with round-robin arbitration.
- Runs a comma training sequence after reset or on request, and fills unused slots with the idle comma 0xBC.
- Runs in the `clk_4f` domain: one byte per `clk_4f` cycle, so the `clk_32f` serializer shifts one byte per slot.

---
 rtl/ps_tx_scheduler_if.sv | 26 ++
 rtl/ps_tx_scheduler.sv | 111 +++++++++++
 tb/tb_ps_tx_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_tx_scheduler_if.sv
// Byte-lane requests, retrain and converter-side outputs of ps_tx_scheduler.
// The master drives lane bytes; the slave (scheduler) grants and emits bytes.
interface ps_tx_scheduler_if;
    logic [7:0] data0_in;
    logic       valid0_in;
    logic [7:0] data1_in;
    logic       valid1_in;
    logic       retrain;
    logic       grant0;
    logic       grant1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       k_out;
    logic       lane_out;
    logic       link_up;

    modport master (
        output data0_in, valid0_in, data1_in, valid1_in, retrain,
        input  grant0, grant1, data_out, valid_out, k_out, lane_out, link_up
    );

    modport slave (
        input  data0_in, valid0_in, data1_in, valid1_in, retrain,
        output grant0, grant1, data_out, valid_out, k_out, lane_out, link_up
    );
endinterface

// File: rtl/ps_tx_scheduler.sv
// Two-lane round-robin byte scheduler with comma training for the P2S converter.
// Optional periodic skip symbols are enabled by defining SCHED_SKIP_EN.
module ps_tx_scheduler #(
    parameter int         TRAIN_LEN   = 4,
    parameter logic [7:0] IDLE_SYM    = 8'hBC,
    parameter logic [7:0] SKIP_SYM    = 8'h1C,
    parameter int         SKIP_PERIOD = 16
) (
    input  logic             clk_4f,
    input  logic             reset,
    ps_tx_scheduler_if.slave bus
);

    typedef enum logic {TRAIN, ACTIVE} state_t;

    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 1);

    state_t     state;
    logic [7:0] train_cnt;
    logic       last;
    logic       skip_slot;
    logic       arb_ok;
    logic       take0;
    logic       take1;

`ifdef SCHED_SKIP_EN
    localparam int            SW        = $clog2(SKIP_PERIOD);
    localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_PERIOD - 1);

    logic [SW-1:0] skip_cnt;

    assign skip_slot = (state == ACTIVE) && (skip_cnt == SKIP_LAST);

    // Held at zero outside ACTIVE so every entry starts a fresh period.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset)
            skip_cnt <= '0;
        else if (state != ACTIVE || skip_slot)
            skip_cnt <= '0;
        else
            skip_cnt <= skip_cnt + 1'b1;
    end
`else
    assign skip_slot = 1'b0;

    wire unused_skip = ^{SKIP_SYM, 8'(SKIP_PERIOD)};
`endif

    assign arb_ok = (state == ACTIVE) && !bus.retrain && !skip_slot;
    assign take0  = arb_ok && bus.valid0_in && (!bus.valid1_in || last);
    assign take1  = arb_ok && bus.valid1_in && (!bus.valid0_in || !last);

    assign bus.grant0 = take0;
    assign bus.grant1 = take1;

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state         <= TRAIN;
            train_cnt     <= '0;
            last          <= 1'b1;
            bus.data_out  <= IDLE_SYM;
            bus.valid_out <= 1'b0;
            bus.k_out     <= 1'b1;
            bus.lane_out  <= 1'b0;
            bus.link_up   <= 1'b0;
        end else begin
            unique case (state)
                TRAIN: begin
                    bus.data_out  <= IDLE_SYM;
                    bus.valid_out <= 1'b0;
                    bus.k_out     <= 1'b1;
                    if (bus.retrain) begin
                        train_cnt <= '0;
                    end else if (train_cnt == TRAIN_LAST) begin
                        train_cnt   <= '0;
                        state       <= ACTIVE;
                        bus.link_up <= 1'b1;
                    end else begin
                        train_cnt <= train_cnt + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (bus.retrain) begin
                        state         <= TRAIN;
                        train_cnt     <= '0;
                        bus.link_up   <= 1'b0;
                        bus.data_out  <= IDLE_SYM;
                        bus.valid_out <= 1'b0;
                        bus.k_out     <= 1'b1;
                    end else if (skip_slot) begin
                        bus.data_out  <= SKIP_SYM;
                        bus.valid_out <= 1'b0;
                        bus.k_out     <= 1'b1;
                    end else if (take0 || take1) begin
                        bus.data_out  <= take1 ? bus.data1_in : bus.data0_in;
                        bus.valid_out <= 1'b1;
                        bus.k_out     <= 1'b0;
                        bus.lane_out  <= take1;
                        last          <= take1;
                    end else begin
                        bus.data_out  <= IDLE_SYM;
                        bus.valid_out <= 1'b0;
                        bus.k_out     <= 1'b1;
                    end
                end
                default: state <= TRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Randomized bench for ps_tx_scheduler against a cycle-level reference model.
// Lane requesters hold bytes until granted; directed bytes come from per-lane queues.
module tb_ps_tx_scheduler;

    localparam int         TRAIN_LEN   = 4;
    localparam logic [7:0] IDLE        = 8'hBC;
    localparam logic [7:0] SKIP        = 8'h1C;
    localparam int         SKIP_PERIOD = 16;

    logic clk_4f = 1'b0;
    logic reset  = 1'b1;

    ps_tx_scheduler_if bus ();

    ps_tx_scheduler #(
        .TRAIN_LEN   (TRAIN_LEN),
        .IDLE_SYM    (IDLE),
        .SKIP_SYM    (SKIP),
        .SKIP_PERIOD (SKIP_PERIOD)
    ) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_4f = ~clk_4f;

    logic [7:0] r_d0 = 8'h00;
    logic [7:0] r_d1 = 8'h00;
    logic       r_v0 = 1'b0;
    logic       r_v1 = 1'b0;
    logic       r_rt = 1'b0;

    assign bus.data0_in  = r_d0;
    assign bus.valid0_in = r_v0;
    assign bus.data1_in  = r_d1;
    assign bus.valid1_in = r_v1;
    assign bus.retrain   = r_rt;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: link phase, commas sent, cycles spent ACTIVE.
    bit         m_active;
    int         m_commas;
    int         m_act;
    bit         m_last;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_k;
    bit         e_lane;
    bit         e_link;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_commas = 0;
        m_act    = 0;
        m_last   = 1'b1;
        e_data   = IDLE;
        e_valid  = 1'b0;
        e_k      = 1'b1;
        e_lane   = 1'b0;
        e_link   = 1'b0;
    endtask

    function automatic bit skip_now();
`ifdef SCHED_SKIP_EN
        return m_active && ((m_act % SKIP_PERIOD) == SKIP_PERIOD - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic calc_grant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_active && !r_rt && !skip_now()) begin
            if (r_v0 && r_v1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = r_v0;
                g1 = r_v1;
            end
        end
    endtask

    task automatic check_outputs(input string sfx);
        check({"data_out", sfx},  bus.data_out,  e_data);
        check({"valid_out", sfx}, bus.valid_out, e_valid);
        check({"k_out", sfx},     bus.k_out,     e_k);
        check({"lane_out", sfx},  bus.lane_out,  e_lane);
        check({"link_up", sfx},   bus.link_up,   e_link);
    endtask

    task automatic refill(input int load);
        if (!r_v0) begin
            if (q0.size() > 0) begin
                r_v0 = 1'b1;
                r_d0 = q0.pop_front();
            end else if ($urandom_range(99) < load) begin
                r_v0 = 1'b1;
                r_d0 = 8'($urandom);
            end
        end
        if (!r_v1) begin
            if (q1.size() > 0) begin
                r_v1 = 1'b1;
                r_d1 = q1.pop_front();
            end else if ($urandom_range(99) < load) begin
                r_v1 = 1'b1;
                r_d1 = 8'($urandom);
            end
        end
    endtask

    task automatic step(input int load, input int rt_pct);
        bit g0;
        bit g1;
        #1;
        calc_grant(g0, g1);
        check("grant0", bus.grant0, g0);
        check("grant1", bus.grant1, g1);
        @(posedge clk_4f);
        if (!m_active) begin
            e_data  = IDLE;
            e_valid = 1'b0;
            e_k     = 1'b1;
            if (r_rt) begin
                m_commas = 0;
            end else begin
                m_commas++;
                if (m_commas == TRAIN_LEN) begin
                    m_active = 1'b1;
                    m_act    = 0;
                    e_link   = 1'b1;
                end
            end
        end else if (r_rt) begin
            m_active = 1'b0;
            m_commas = 0;
            e_link   = 1'b0;
            e_data   = IDLE;
            e_valid  = 1'b0;
            e_k      = 1'b1;
        end else begin
            if (skip_now()) begin
                e_data  = SKIP;
                e_valid = 1'b0;
                e_k     = 1'b1;
            end else if (g0 || g1) begin
                e_data  = g1 ? r_d1 : r_d0;
                e_valid = 1'b1;
                e_k     = 1'b0;
                e_lane  = g1;
                m_last  = g1;
            end else begin
                e_data  = IDLE;
                e_valid = 1'b0;
                e_k     = 1'b1;
            end
            m_act++;
        end
        #1;
        check_outputs("");
        if (g0) r_v0 = 1'b0;
        if (g1) r_v1 = 1'b0;
        r_rt = ($urandom_range(99) < rt_pct);
        refill(load);
    endtask

    task automatic check_reset_values(input string sfx);
        check({"rst_data", sfx},  bus.data_out,  IDLE);
        check({"rst_valid", sfx}, bus.valid_out, 0);
        check({"rst_k", sfx},     bus.k_out,     1);
        check({"rst_lane", sfx},  bus.lane_out,  0);
        check({"rst_link", sfx},  bus.link_up,   0);
        check({"rst_g0", sfx},    bus.grant0,    0);
        check({"rst_g1", sfx},    bus.grant1,    0);
    endtask

    task automatic async_reset();
        @(negedge clk_4f);
        #2;
        r_rt  = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("_async");
        model_reset();
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_4f);
        @(negedge clk_4f);
        check_reset_values("");

        // Training with lane 0 already requesting 0x9D.
        r_v0  = 1'b1;
        r_d0  = 8'h9D;
        reset = 1'b0;
        for (int i = 0; i < TRAIN_LEN + 3; i++) step(0, 0);

        // Single-lane back-to-back stream.
        q0.push_back(8'hFF);
        q0.push_back(8'hEE);
        q0.push_back(8'hAF);
        refill(0);
        for (int i = 0; i < 5; i++) step(0, 0);

        // Contention with both lanes loaded together.
        q0.push_back(8'h11);
        q0.push_back(8'h12);
        q1.push_back(8'h21);
        q1.push_back(8'h22);
        refill(0);
        for (int i = 0; i < 6; i++) step(0, 0);

        // Retrain pulse while both lanes are saturated.
        for (int i = 0; i < 3; i++) step(100, 0);
        r_rt = 1'b1;
        for (int i = 0; i < TRAIN_LEN + 6; i++) step(100, 0);

        // Randomized traffic with occasional retrain and async resets.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 500; i++) step(55, 2);
            async_reset();
        end

        // Saturated traffic long enough to cover many skip periods.
        for (int i = 0; i < 300; i++) step(100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
